nibble_serial_addsub_ctrl: RTL

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one adder_4bit slice, one nibble per clock, LSB nibble first. It latches operands on a start handshake, feeds each nibble and the rippled carry through the slice, and assembles the result and flags. It sits between the ALU decode and the shared 4-bit adder, giving a small-area wide add/sub for the RISC datapath.

---
 rtl/nibble_serial_addsub_ctrl_pkg.sv | 13 +
 rtl/nibble_serial_addsub_ctrl_adder_4bit.sv | 16 +
 rtl/nibble_serial_addsub_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// nibble_serial_addsub_ctrl_pkg: shared state encoding and ALU op constants
package nibble_serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_adder_4bit.sv
// adder_4bit: shared 4-bit add/sub slice, mode=1 inverts b for subtraction
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       mode,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] bm;

    assign bm        = mode ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, bm} + {4'b0, cin};

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: WIDTH-bit add/sub run one nibble per clock through a shared 4-bit slice
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = $clog2(NIBBLES);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q, res_n;
    logic             op_q, carry, sc, accept, last, ov_n;
    logic [IW-1:0]    idx;
    logic [3:0]       s;

    adder_4bit u_slice (
        .a    (a_q[{idx, 2'b00} +: 4]),
        .b    (b_q[{idx, 2'b00} +: 4]),
        .cin  (carry),
        .mode (op_q),
        .s    (s),
        .cout (sc)
    );

    assign busy   = state == ST_RUN;
    assign done   = state == ST_DONE;
    assign accept = start && state != ST_RUN;
    assign last   = idx == IW'(NIBBLES - 1);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = accept ? ST_RUN : ST_IDLE;
            ST_RUN:  state_n = last ? ST_DONE : ST_RUN;
            ST_DONE: state_n = accept ? ST_RUN : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // merged result with the current nibble, so final flags see the full word
    always_comb begin
        res_n = result;
        res_n[{idx, 2'b00} +: 4] = s;
        ov_n = (op_q == OP_SUB ? a_q[WIDTH-1] != b_q[WIDTH-1] : a_q[WIDTH-1] == b_q[WIDTH-1])
               && res_n[WIDTH-1] != a_q[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            idx      <= '0;
            carry    <= op;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state == ST_RUN) begin
            result <= res_n;
            carry  <= sc;
            idx    <= idx + 1'b1;
            if (last) begin
                cout     <= sc;
                overflow <= ov_n;
                zero     <= res_n == '0;
            end
        end
    end

endmodule
